uart_rx_tx_bridge: RTL and testbench

//  Buffered, parametrised byte processor between the UART RX and UART TX modules.
//  - Each received byte enters a FIFO and is transformed (pass / add / xor / invert).
//  - Each byte is handed to TX exactly once, using a start/done handshake.
//  - Every byte is forwarded; repeated values are not suppressed.
//  - Bytes are dropped only on FIFO overflow, and the drop is flagged.

---
 rtl/uart_bridge_pkg.sv | 32 +++
 rtl/uart_byte_fifo.sv | 55 +++++
 rtl/uart_rx_tx_bridge.sv | 137 +++++++++++++
 tb/tb_uart_rx_tx_bridge.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART RX -> TX byte bridge.
//   MODE_*  : encodings of the i_mode transform selector
//   state_t : bridge FSM states
//   xform() : byte transform applied when a byte leaves the FIFO
package uart_bridge_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_ADD  = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_INV  = 2'd3;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    // Works on a 32-bit container so any DATA_W up to 32 can share it; the
    // caller truncates the result, which also makes MODE_ADD wrap modulo
    // 2^DATA_W.
    function automatic logic [31:0] xform(input logic [31:0] data,
                                          input logic [1:0]  mode,
                                          input logic [31:0] offset,
                                          input logic [31:0] key);
        case (mode)
            MODE_ADD: return data + offset;
            MODE_XOR: return data ^ key;
            MODE_INV: return ~data;
            default:  return data;
        endcase
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers.
//   clk, reset : clock, asynchronous active-low reset
//   push, din  : write din when push and not full
//   pop        : advance read pointer when pop and not empty
//   dout       : head entry (combinational read)
//   empty/full : pointer-compare status
//   level      : occupancy 0..DEPTH
module uart_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level
);

    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic              do_push;
    logic              do_pop;

    // Pointers run modulo 2*DEPTH; the extra MSB separates full from empty.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                     (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign level   = wptr - rptr;
    assign dout    = mem[rptr[ADDR_W-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[ADDR_W-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_tx_bridge.sv
// Buffered byte processor between UART RX and UART TX.
// Received bytes are queued, transformed on the way out (pass/add/xor/invert)
// and handed to TX one at a time with a start/done handshake.
//   clk, reset    : clock, asynchronous active-low reset
//   i_rx_byte/dv  : incoming byte and its 1-cycle strobe
//   i_tx_active   : TX serializer busy, blocks a new start
//   i_tx_done     : 1-cycle strobe, TX finished current byte
//   i_mode        : transform select, sampled when a byte is popped
//   i_clr_ovf     : clears o_overflow (a same-cycle drop wins)
//   o_tx_byte/dv  : byte to TX and its 1-cycle start strobe
//   o_busy        : waiting for i_tx_done
//   o_fifo_level  : FIFO occupancy
//   o_overflow    : sticky, a byte was dropped on a full FIFO
// Optional macro UART_BRIDGE_STATS_EN adds saturating 16-bit counters
// o_rx_cnt (accepted), o_tx_cnt (start strobes), o_drop_cnt (dropped).
//
// state  | meaning
// S_IDLE | no byte in flight; start the next one when FIFO has data and TX idle
// S_WAIT | byte handed to TX; waiting for i_tx_done
module uart_rx_tx_bridge
    import uart_bridge_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                DEPTH   = 16,
    parameter logic [DATA_W-1:0] OFFSET  = 8'd10,
    parameter logic [DATA_W-1:0] XOR_KEY = 8'hA5,
    parameter int                ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_rx_byte,
    input  logic              i_rx_dv,
    input  logic              i_tx_active,
    input  logic              i_tx_done,
    input  logic [1:0]        i_mode,
    input  logic              i_clr_ovf,
    output logic [DATA_W-1:0] o_tx_byte,
    output logic              o_tx_dv,
    output logic              o_busy,
    output logic [ADDR_W:0]   o_fifo_level,
    output logic              o_overflow
`ifdef UART_BRIDGE_STATS_EN
    ,
    output logic [15:0]       o_rx_cnt,
    output logic [15:0]       o_tx_cnt,
    output logic [15:0]       o_drop_cnt
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic              pop;
    logic              push;
    logic              drop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_dout;
    logic [DATA_W-1:0] tx_byte_nxt;

    // Full is the registered status, so a pop in the same cycle does not
    // make room for the incoming byte.
    assign push = i_rx_dv && !fifo_full;
    assign drop = i_rx_dv && fifo_full;

    uart_byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (i_rx_byte),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (o_fifo_level)
    );

    assign tx_byte_nxt = DATA_W'(xform(32'(fifo_dout), i_mode,
                                       32'(OFFSET), 32'(XOR_KEY)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && !i_tx_active) begin
                    pop       = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_tx_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_busy = (state == S_WAIT);

    // o_tx_byte is only loaded on a pop, so it stays valid through the
    // whole TX transfer and after i_tx_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_tx_dv    <= 1'b0;
            o_tx_byte  <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_tx_dv <= pop;
            if (pop) o_tx_byte <= tx_byte_nxt;
            if (drop)           o_overflow <= 1'b1;
            else if (i_clr_ovf) o_overflow <= 1'b0;
        end
    end

`ifdef UART_BRIDGE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_rx_cnt   <= '0;
            o_tx_cnt   <= '0;
            o_drop_cnt <= '0;
        end else begin
            if (push && o_rx_cnt   != 16'hFFFF) o_rx_cnt   <= o_rx_cnt   + 16'd1;
            if (pop  && o_tx_cnt   != 16'hFFFF) o_tx_cnt   <= o_tx_cnt   + 16'd1;
            if (drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_tx_bridge.sv
`timescale 1ns/1ps
module tb_uart_rx_tx_bridge;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] i_rx_byte = '0;
    logic       i_rx_dv = 1'b0;
    logic       i_tx_active = 1'b0;
    logic       i_tx_done;
    logic [1:0] i_mode = '0;
    logic       i_clr_ovf = 1'b0;
    logic [7:0] o_tx_byte;
    logic       o_tx_dv;
    logic       o_busy;
    logic [2:0] o_fifo_level;
    logic       o_overflow;
`ifdef UART_BRIDGE_STATS_EN
    logic [15:0] o_rx_cnt, o_tx_cnt, o_drop_cnt;
`endif

    uart_rx_tx_bridge #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rx_byte    (i_rx_byte),
        .i_rx_dv      (i_rx_dv),
        .i_tx_active  (i_tx_active),
        .i_tx_done    (i_tx_done),
        .i_mode       (i_mode),
        .i_clr_ovf    (i_clr_ovf),
        .o_tx_byte    (o_tx_byte),
        .o_tx_dv      (o_tx_dv),
        .o_busy       (o_busy),
        .o_fifo_level (o_fifo_level),
        .o_overflow   (o_overflow)
`ifdef UART_BRIDGE_STATS_EN
        ,
        .o_rx_cnt     (o_rx_cnt),
        .o_tx_cnt     (o_tx_cnt),
        .o_drop_cnt   (o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: a bounded queue of raw bytes plus flags and counts.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    int         m_rx = 0, m_tx = 0, m_drop = 0;
    logic [1:0] mode_at_edge = '0;
    int         n_strobe = 0;
    bit         auto_done = 1'b0;
    int         done_req = 0, done_ack = 0, cnt = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] ref_f(input logic [7:0] b, input logic [1:0] m);
        int v;
        v = int'(b);
        case (m)
            2'd1:    v = (v + 10) % 256;
            2'd2:    v = v ^ 'hA5;
            2'd3:    v = 255 - v;
            default: v = v;
        endcase
        return 8'(v);
    endfunction

    // Stimulus side of the scoreboard: what the DUT accepts at each edge.
    always @(posedge clk) begin
        if (reset) begin
            mode_at_edge = i_mode;
            if (i_rx_dv && q.size() >= DEPTH) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end else begin
                if (i_clr_ovf) m_ovf = 1'b0;
                if (i_rx_dv) begin
                    q.push_back(i_rx_byte);
                    if (m_rx < 65535) m_rx++;
                end
            end
        end
    end

    // Monitor: pops and compares whenever the DUT strobes a byte out.
    always @(negedge clk) begin
        if (!reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_rx = 0; m_tx = 0; m_drop = 0;
        end else begin
            if (o_tx_dv) begin
                n_strobe++;
                if (m_tx < 65535) m_tx++;
                if (q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL spurious_tx_dv: got strobe byte %0h expected none at %0t",
                             o_tx_byte, $time);
                end else begin
                    check("tx_byte", 32'(o_tx_byte), 32'(ref_f(q.pop_front(), mode_at_edge)));
                end
            end
            check("fifo_level", 32'(o_fifo_level), 32'(q.size()));
            check("overflow", 32'(o_overflow), 32'(m_ovf));
`ifdef UART_BRIDGE_STATS_EN
            check("rx_cnt", 32'(o_rx_cnt), 32'(m_rx));
            check("tx_cnt", 32'(o_tx_cnt), 32'(m_tx));
            check("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
`endif
        end
    end

    // TX emulator: acknowledges strobes after a random delay, or on request.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            i_tx_done = 1'b0;
            if (!reset) cnt = 0;
            else if (done_req != done_ack) begin
                done_ack++;
                i_tx_done = 1'b1;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) i_tx_done = 1'b1;
            end else if (o_tx_dv && auto_done) begin
                cnt = $urandom_range(0, 3);
                if (cnt == 0) i_tx_done = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_byte = b; i_rx_dv = 1'b1;
        tick();
        i_rx_dv = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q.size() != 0 || o_busy) && k < 400) begin
            tick(); k++;
        end
        check("drain_in_time", 32'(k < 400), 32'd1);
        repeat (2) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_dv"}, 32'(o_tx_dv), 0);
        check({tag, "_tx_byte"}, 32'(o_tx_byte), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_level"}, 32'(o_fifo_level), 0);
        check({tag, "_overflow"}, 32'(o_overflow), 0);
    endtask

    // One byte in a given mode; mode is changed while in flight, and the
    // byte must survive that and the following done.
    task automatic one_byte(input logic [1:0] m, input logic [7:0] b, input logic [7:0] exp);
        int k;
        i_mode = m;
        send(b);
        k = 0;
        while (!o_tx_dv && k < 10) begin tick(); k++; end
        check("mode_strobe_seen", 32'(o_tx_dv), 1);
        i_mode = m + 2'd1;
        tick();
        check("mode_inflight_byte", 32'(o_tx_byte), 32'(exp));
        done_req++;
        repeat (3) tick();
        check("mode_hold_after_done", 32'(o_tx_byte), 32'(exp));
        check("mode_idle_after_done", 32'(o_busy), 0);
    endtask

    initial begin
        int s0;
        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        reset = 1'b1;
        repeat (2) tick();

        // ADD latency: strobe two cycles after rx_dv
        i_mode = 2'd1;
        send(8'h05);
        @(negedge clk); check("lat_cycle1_dv", 32'(o_tx_dv), 0);
        tick();
        @(negedge clk); check("lat_cycle2_dv", 32'(o_tx_dv), 1);
        check("lat_cycle2_busy", 32'(o_busy), 1);
        tick();
        @(negedge clk); check("strobe_one_cycle", 32'(o_tx_dv), 0);
        tick();
        done_req++;
        repeat (3) tick();
        check("busy_after_done", 32'(o_busy), 0);
        check("byte_held", 32'(o_tx_byte), 32'h0F);

        // Reset in the middle of WAIT
        send(8'h33);
        repeat (3) tick();
        check("pre_reset_busy", 32'(o_busy), 1);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        tick();
        reset = 1'b1;
        s0 = n_strobe;
        repeat (6) tick();
        check("no_strobe_after_reset", 32'(n_strobe - s0), 0);

        // Repeated values are all forwarded
        auto_done = 1'b1;
        s0 = n_strobe;
        send(8'h41);
        send(8'h41);
        drain();
        check("dup_strobes", 32'(n_strobe - s0), 2);

        // Overflow with TX held off
        i_tx_active = 1'b1;
        for (int i = 1; i <= 6; i++) send(8'(i));
        @(negedge clk);
        check("ovf_level", 32'(o_fifo_level), 32'(DEPTH));
        check("ovf_flag", 32'(o_overflow), 1);
`ifdef UART_BRIDGE_STATS_EN
        check("ovf_drop_cnt", 32'(o_drop_cnt), 2);
`endif
        tick();
        i_tx_active = 1'b0;
        drain();

        // Push into a full FIFO while it pops; clear vs drop priority
        auto_done = 1'b0;
        i_clr_ovf = 1'b1; tick(); i_clr_ovf = 1'b0;
        i_tx_active = 1'b1;
        for (int i = 0; i < DEPTH; i++) send(8'($urandom_range(0, 255)));
        i_tx_active = 1'b0;
        i_rx_byte = 8'h77; i_rx_dv = 1'b1;
        tick();
        i_rx_dv = 1'b0; i_tx_active = 1'b1;
        @(negedge clk);
        check("pushpop_full_level", 32'(o_fifo_level), 32'(DEPTH - 1));
        check("pushpop_full_ovf", 32'(o_overflow), 1);
        check("pushpop_full_dv", 32'(o_tx_dv), 1);
        tick();
        send(8'h88);
        i_clr_ovf = 1'b1; i_rx_byte = 8'h99; i_rx_dv = 1'b1;
        tick();
        i_rx_dv = 1'b0;
        @(negedge clk);
        check("clr_vs_drop_ovf", 32'(o_overflow), 1);
        tick();
        i_clr_ovf = 1'b0;
        @(negedge clk);
        check("clr_alone_ovf", 32'(o_overflow), 0);
        tick();
        auto_done = 1'b1;
        i_tx_active = 1'b0;
        done_req++;
        drain();

        // Mode table, with mode changed while the byte is in flight
        auto_done = 1'b0;
        one_byte(2'd1, 8'hFA, 8'h04);
        one_byte(2'd2, 8'h0F, 8'hAA);
        one_byte(2'd3, 8'h0F, 8'hF0);
        one_byte(2'd0, 8'h5C, 8'h5C);

        // Random traffic
        auto_done = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            i_rx_dv     = ($urandom_range(0, 2) == 0);
            i_rx_byte   = 8'($urandom_range(0, 255));
            i_tx_active = ($urandom_range(0, 3) == 0);
            i_clr_ovf   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) i_mode = 2'($urandom_range(0, 3));
            tick();
        end
        i_rx_dv = 1'b0; i_tx_active = 1'b0; i_clr_ovf = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
